// File: rtl/switch_endpoint.sv
// Host-side endpoint for one switch port: a TX FIFO drained over the validtx/acktx
// handshake with per-destination backpressure and timeout retry, plus an RX FIFO filled over validrx/ackrx.
module switch_endpoint #(
    parameter int DW      = 4,
    parameter int N       = 4,
    parameter int AW      = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tx_wr_i,
    input  logic [DW-1:0] tx_dat_i,
    input  logic [AW-1:0] tx_adr_i,
    output logic          tx_full_o,
    output logic          tx_timeout_o,
    input  logic          rx_rd_i,
    output logic [DW-1:0] rx_dat_o,
    output logic          rx_empty_o,
    output logic          validtx_o,
    output logic [DW-1:0] dat_o,
    output logic [AW-1:0] adr_o,
    input  logic          acktx_i,
    input  logic [N-1:0]  full_array_i,
    input  logic          validrx_i,
    input  logic [DW-1:0] dat_i,
    output logic          ackrx_o,
    output logic          full_o
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_GAP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rx_state_t;

    // ---------------------------------------------------------------- TX FIFO
    logic [AW+DW-1:0] r_tx_mem [DEPTH];
    logic [PW-1:0]    r_tx_wr_ptr;
    logic [PW-1:0]    r_tx_rd_ptr;
    logic [PW-1:0]    w_tx_count;
    logic             w_tx_empty;
    logic             w_tx_full;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic [AW+DW-1:0] w_tx_head;
    logic [AW-1:0]    w_head_adr;
    logic [DW-1:0]    w_head_dat;
    logic             w_dest_full;

    tx_state_t        r_tx_state;
    logic [CW-1:0]    r_tx_cnt;
    logic             r_validtx;
    logic [DW-1:0]    r_dat;
    logic [AW-1:0]    r_adr;
    logic             r_tx_timeout;

    assign w_tx_count  = r_tx_wr_ptr - r_tx_rd_ptr;
    assign w_tx_empty  = (r_tx_wr_ptr == r_tx_rd_ptr);
    assign w_tx_full   = (w_tx_count == PW'(DEPTH));
    assign w_tx_push   = tx_wr_i && !w_tx_full;
    assign w_tx_pop    = (r_tx_state == T_REQ) && acktx_i && !w_tx_empty;
    assign w_tx_head   = r_tx_mem[r_tx_rd_ptr[PW-2:0]];
    assign w_head_adr  = w_tx_head[AW+DW-1:DW];
    assign w_head_dat  = w_tx_head[DW-1:0];
    assign w_dest_full = full_array_i[w_head_adr];

    // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr[PW-2:0]] <= {tx_adr_i, tx_dat_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + PW'(1);
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + PW'(1);
        end
    end

    // TX sender: offer the head word, retry it after TIMEOUT cycles without an ack
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_state   <= T_IDLE;
            r_tx_cnt     <= '0;
            r_validtx    <= 1'b0;
            r_dat        <= '0;
            r_adr        <= '0;
            r_tx_timeout <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle and are raised only by the branch that fires them.
            r_tx_timeout <= 1'b0;
            case (r_tx_state)
                T_IDLE: begin
                    if (!w_tx_empty && !w_dest_full) begin
                        r_dat      <= w_head_dat;
                        r_adr      <= w_head_adr;
                        r_validtx  <= 1'b1;
                        r_tx_cnt   <= '0;
                        r_tx_state <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (acktx_i) begin
                        r_validtx  <= 1'b0;
                        r_tx_state <= T_GAP;
                    end else if (r_tx_cnt == CW'(TIMEOUT - 1)) begin
                        r_validtx    <= 1'b0;
                        r_tx_timeout <= 1'b1;
                        r_tx_state   <= T_GAP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                T_GAP: begin
                    r_tx_cnt   <= '0;
                    r_tx_state <= T_IDLE;
                end
                default: begin
                    r_validtx  <= 1'b0;
                    r_tx_state <= T_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [DW-1:0] r_rx_mem [DEPTH];
    logic [PW-1:0] r_rx_wr_ptr;
    logic [PW-1:0] r_rx_rd_ptr;
    logic [PW-1:0] w_rx_count;
    logic          w_rx_empty;
    logic          w_rx_full;
    logic          w_rx_push;
    logic          w_rx_pop;

    rx_state_t     r_rx_state;
    logic          r_ackrx;

    assign w_rx_count = r_rx_wr_ptr - r_rx_rd_ptr;
    assign w_rx_empty = (r_rx_wr_ptr == r_rx_rd_ptr);
    assign w_rx_full  = (w_rx_count == PW'(DEPTH));
    assign w_rx_push  = (r_rx_state == R_IDLE) && validrx_i && !w_rx_full;
    assign w_rx_pop   = rx_rd_i && !w_rx_empty;

    always_ff @(posedge clk_i) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr[PW-2:0]] <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
        end else begin
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + PW'(1);
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + PW'(1);
        end
    end

    // RX receiver: one capture per delivery, then wait for validrx to drop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_state <= R_IDLE;
            r_ackrx    <= 1'b0;
        end else begin
            case (r_rx_state)
                R_IDLE: begin
                    if (w_rx_push) begin
                        r_ackrx    <= 1'b1;
                        r_rx_state <= R_ACK;
                    end
                end
                R_ACK: begin
                    r_ackrx    <= 1'b0;
                    r_rx_state <= validrx_i ? R_WAIT : R_IDLE;
                end
                R_WAIT: begin
                    if (!validrx_i) r_rx_state <= R_IDLE;
                end
                default: begin
                    r_ackrx    <= 1'b0;
                    r_rx_state <= R_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign tx_full_o    = w_tx_full;
    assign tx_timeout_o = r_tx_timeout;
    assign validtx_o    = r_validtx;
    assign dat_o        = r_dat;
    assign adr_o        = r_adr;
    assign ackrx_o      = r_ackrx;
    assign full_o       = w_rx_full;
    assign rx_empty_o   = w_rx_empty;
    assign rx_dat_o     = w_rx_empty ? '0 : r_rx_mem[r_rx_rd_ptr[PW-2:0]];

endmodule

// File: doc/switch_endpoint.md
# switch_endpoint

Host-side endpoint for one port of the 4-port packet switch. It buffers outgoing words from local logic and sends each one to a destination port over the validtx/acktx handshake, holding off while that destination's full flag is set. It also accepts words delivered by the switch over the validrx/ackrx handshake into a local RX FIFO. One instance sits on each switch port, opposite the switch-side port logic.

## Interface
- DW, 4: data width.
- N, 4: number of switch ports; width of full_array_i.
- AW, 2: destination address width; must satisfy 2^AW ≥ N.
- DEPTH, 4: entries per FIFO (TX and RX); power of 2, ≥ 2.
- TIMEOUT, 15: cycles in T_REQ without acktx before retry; ≥ 1.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- tx_wr_i  in  1  push tx_dat_i/tx_adr_i into TX FIFO.
- tx_dat_i  in  DW  outgoing word.
- tx_adr_i  in  AW  destination port.
- tx_full_o  out  1  TX FIFO full.
- tx_timeout_o  out  1  one-cycle pulse when a send attempt times out.
- rx_rd_i  in  1  pop the RX FIFO head.
- rx_dat_o  out  DW  RX FIFO head (first-word fall-through); 0 when empty.
- rx_empty_o  out  1  RX FIFO empty.
- validtx_o  out  1  word on dat_o/adr_o offered to switch.
- dat_o  out  DW  outgoing data to switch.
- adr_o  out  AW  outgoing destination to switch.
- acktx_i  in  1  switch accepted the offered word.
- full_array_i  in  N  per-destination full flags from switch.
- validrx_i  in  1  switch delivers dat_i.
- dat_i  in  DW  incoming data from switch.
- ackrx_o  out  1  delivered word captured.
- full_o  out  1  RX FIFO full; feeds the switch's full_array.

## Operation
- FIFOs: AW+1-bit-style pointers, log2(DEPTH)+1 bits with a wrap bit. A write when full is ignored, even if a read occurs in the same cycle. A read when empty is ignored. Simultaneous read and write when neither full nor empty leaves the count unchanged.
- TX FSM, states T_IDLE, T_REQ, T_GAP:
  - T_IDLE: if the TX FIFO is non-empty and full_array_i[head.adr] = 0:
    - load dat_o/adr_o from the head;
    - validtx_o ← 1;
    - go to T_REQ.
    - Otherwise stay, with validtx_o = 0.
  - T_REQ: hold validtx_o, dat_o and adr_o stable. Changes on full_array_i are ignored once committed. Timeout counter increments each cycle.
    - acktx_i = 1: pop the TX FIFO, validtx_o ← 0, go to T_GAP.
    - Counter reaches TIMEOUT with no ack: validtx_o ← 0, no pop, tx_timeout_o pulses, go to T_GAP. The same head is retried.
  - T_GAP: one cycle with validtx_o = 0; counter cleared; go to T_IDLE.
- RX FSM, states R_IDLE, R_ACK, R_WAIT:
  - R_IDLE: if validrx_i = 1 and the RX FIFO is not full: write dat_i, ackrx_o ← 1, go to R_ACK. If the FIFO is full, stay with no ack.
  - R_ACK: ackrx_o ← 0. Go to R_WAIT if validrx_i = 1, else to R_IDLE.
  - R_WAIT: stay until validrx_i is sampled 0, then go to R_IDLE. This guarantees one capture per delivery.
- full_o = RX count == DEPTH. tx_full_o = TX count == DEPTH. Both are derived combinationally from the registered count.

## Timing
- Reset values: validtx_o 0, dat_o 0, adr_o 0, ackrx_o 0, tx_timeout_o 0, tx_full_o 0, full_o 0, rx_empty_o 1, rx_dat_o 0.
  - FIFOs are emptied and FSMs go to T_IDLE/R_IDLE.
  - Reset asserted mid-transfer drops validtx_o and ackrx_o after that edge; the in-flight word is lost.
- Edge numbering: a push is sampled at edge k.
  - The FIFO is non-empty after edge k.
  - validtx_o is high after edge k+1, so write-to-request latency is 2 cycles when the destination is not full.
- acktx_i sampled at edge m:
  - validtx_o is low after edge m and the pop takes effect at edge m.
  - The next validtx_o rises no earlier than after edge m+2.
- validrx_i sampled at edge r in R_IDLE:
  - The word is in the FIFO and ackrx_o is high after edge r, for exactly 1 cycle.
  - rx_empty_o falls after edge r and rx_dat_o is valid the same cycle.
- Timeout: validtx_o stays high for exactly TIMEOUT cycles. tx_timeout_o is high in the cycle after the drop.
- Simultaneous rx_rd_i with a capture on an empty FIFO: the read is ignored and the word remains.

## Test plan
- Reset, then push (dat 4'hA, adr 2) → validtx_o=1, dat_o=A, adr_o=2 two cycles after push. Ack after 3 cycles → validtx_o=0 next cycle, tx_full_o=0, FIFO empty.
- full_array_i=4'b0100, push adr 2 → validtx_o stays 0. Clear bit 2 → validtx_o rises one cycle later.
- Push 4 words, acktx_i never asserted → validtx_o high for 15 cycles, then a tx_timeout_o pulse and a 1-cycle gap. Retry shows the same dat_o. A 5th push while full is ignored.
- Switch holds validrx_i=1 with dat_i=4'h3 for 5 cycles → exactly one ackrx_o pulse and one FIFO entry; rx_dat_o=3.
- Deliver 4 words without reading → full_o=1. A 5th validrx_i gets no ackrx_o until rx_rd_i frees a slot, then it is captured.
- Assert rst_i during T_REQ and R_WAIT → all outputs at reset values after that edge; rx_empty_o=1.
